xix_ld_exec_seq: RTL and testbench

- Execution sequencer for the indexed loads/stores LD r,(IX/IY+d) and LD (IX/IY+d),r.
- Consumes the one-hot set lines from the XIX opcode decoder after the DD/FD opcode fetch completes.
- Runs the displacement read, the address-compute and the memory read/write machine cycles, then writes back or stores the register.
- Sits between the decoder latch stage and the bus/register-file interfaces of the core.

---
 rtl/xix_pkg.sv | 30 +++
 rtl/xix_ea_adder.sv | 13 +
 rtl/xix_ld_exec_seq.sv | 189 ++++++++++++++++++
 tb/tb_xix_ld_exec_seq.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/xix_pkg.sv
// Shared types and constants for the indexed-load/store execution sequencer.
package xix_pkg;

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    D1   = 4'd1,
    D2   = 4'd2,
    D3   = 4'd3,
    ADDR = 4'd4,
    M1   = 4'd5,
    M2   = 4'd6,
    M3   = 4'd7,
    FIN  = 4'd8
  } state_e;

  localparam logic [6:0] REG_B = 7'b000_0001;
  localparam logic [6:0] REG_C = 7'b000_0010;
  localparam logic [6:0] REG_D = 7'b000_0100;
  localparam logic [6:0] REG_E = 7'b000_1000;
  localparam logic [6:0] REG_H = 7'b001_0000;
  localparam logic [6:0] REG_L = 7'b010_0000;
  localparam logic [6:0] REG_A = 7'b100_0000;

  localparam int ADDR_TSTATES_DFLT = 5;

  function automatic logic is_onehot7(input logic [6:0] v);
    return (v != 7'd0) && ((v & (v - 7'd1)) == 7'd0);
  endfunction

endpackage

// File: rtl/xix_ea_adder.sv
// Effective address: 16-bit index base plus sign-extended 8-bit displacement, wrapping mod 2^16.
module xix_ea_adder (
  input  logic [15:0] i_base,
  input  logic [7:0]  i_disp,
  output logic [15:0] o_ea
);

  logic [15:0] w_disp_sx;

  assign w_disp_sx = {{8{i_disp[7]}}, i_disp};
  assign o_ea      = i_base + w_disp_sx;

endmodule

// File: rtl/xix_ld_exec_seq.sv
// Sequencer for LD r,(IX/IY+d) and LD (IX/IY+d),r: displacement fetch, EA compute, memory cycle, write-back.
module xix_ld_exec_seq
  import xix_pkg::*;
#(
  parameter int ADDR_TSTATES = ADDR_TSTATES_DFLT,
  parameter bit WAIT_ENABLE  = 1'b1
) (
  input  logic        CLK,
  input  logic        notReset,
  input  logic        go,
  input  logic        is_Y,
  input  logic        is_store,
  input  logic [6:0]  reg_sel,
  input  logic [15:0] IX,
  input  logic [15:0] IY,
  input  logic [15:0] PC,
  input  logic [7:0]  reg_rdata,
  input  logic        notWAIT,
  input  logic [7:0]  mem_rdata,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  output logic        pc_inc,
  output logic        reg_we,
  output logic [6:0]  reg_wsel,
  output logic [7:0]  reg_wdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [3:0] CNT_INIT = 4'(ADDR_TSTATES - 1);

  state_e      r_state;
  state_e      w_next;

  logic        r_is_y;
  logic        r_is_store;
  logic [6:0]  r_sel;
  logic [7:0]  r_d;
  logic [15:0] r_ea;
  logic [3:0]  r_cnt;
  logic [7:0]  r_rdata;
  logic [7:0]  r_wdata;

  logic [15:0] r_addr;
  logic        r_rd;
  logic        r_wr;
  logic        r_pc_inc;
  logic        r_we;
  logic        r_done;
  logic        r_err;

  logic        w_go_ok;
  logic        w_wait;
  logic        w_first_addr;
  logic [15:0] w_base;
  logic [15:0] w_ea;

  logic [15:0] w_addr;
  logic        w_rd;
  logic        w_wr;
  logic        w_pc_inc;
  logic        w_we;
  logic        w_done;

  assign w_go_ok      = go && is_onehot7(reg_sel);
  assign w_wait       = WAIT_ENABLE && !notWAIT;
  assign w_first_addr = (r_cnt == CNT_INIT);
  assign w_base       = r_is_y ? IY : IX;

  xix_ea_adder u_ea (
    .i_base (w_base),
    .i_disp (r_d),
    .o_ea   (w_ea)
  );

  always_ff @(posedge CLK or negedge notReset) begin
    if (!notReset) r_state <= IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_go_ok) w_next = D1;
      D1:      w_next = D2;
      D2:      if (!w_wait) w_next = D3;
      D3:      w_next = ADDR;
      ADDR:    if (r_cnt == 4'd0) w_next = M1;
      M1:      w_next = M2;
      M2:      if (!w_wait) w_next = M3;
      M3:      w_next = FIN;
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so each strobe lines up with its state.
  always_comb begin
    w_addr   = 16'h0000;
    w_rd     = 1'b0;
    w_wr     = 1'b0;
    w_pc_inc = 1'b0;
    w_we     = 1'b0;
    w_done   = 1'b0;
    case (w_next)
      D1, D2, D3: begin
        w_rd     = 1'b1;
        w_addr   = (r_state == IDLE) ? PC : r_addr;
        w_pc_inc = (w_next == D3);
      end
      M1, M2, M3: begin
        w_rd = !r_is_store;
        w_wr = r_is_store && (w_next != M1);
        if (r_state == ADDR) w_addr = w_first_addr ? w_ea : r_ea;
        else                 w_addr = r_addr;
      end
      FIN: begin
        w_we   = !r_is_store;
        w_done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge notReset) begin
    if (!notReset) begin
      r_addr   <= 16'h0000;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_pc_inc <= 1'b0;
      r_we     <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_addr   <= w_addr;
      r_rd     <= w_rd;
      r_wr     <= w_wr;
      r_pc_inc <= w_pc_inc;
      r_we     <= w_we;
      r_done   <= w_done;
      r_err    <= (r_state == IDLE) && go && !is_onehot7(reg_sel);
    end
  end

  always_ff @(posedge CLK or negedge notReset) begin
    if (!notReset) begin
      r_is_y     <= 1'b0;
      r_is_store <= 1'b0;
      r_sel      <= 7'd0;
      r_d        <= 8'h00;
      r_ea       <= 16'h0000;
      r_cnt      <= 4'd0;
      r_rdata    <= 8'h00;
      r_wdata    <= 8'h00;
    end else begin
      if (r_state == IDLE && w_go_ok) begin
        r_is_y     <= is_Y;
        r_is_store <= is_store;
        r_sel      <= reg_sel;
      end
      if (r_state == D3) begin
        r_d   <= mem_rdata;
        r_cnt <= CNT_INIT;
      end else if (r_state == ADDR && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (r_state == ADDR && w_first_addr) r_ea <= w_ea;
      // Store data is taken as M1 begins and held through the write strobe.
      if (r_state == ADDR && w_next == M1 && r_is_store) r_wdata <= reg_rdata;
      if (r_state == M3 && !r_is_store) r_rdata <= mem_rdata;
    end
  end

  assign mem_addr  = r_addr;
  assign mem_rd    = r_rd;
  assign mem_wr    = r_wr;
  assign mem_wdata = r_wdata;
  assign pc_inc    = r_pc_inc;
  assign reg_we    = r_we;
  assign reg_wsel  = r_sel;
  assign reg_wdata = r_rdata;
  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_xix_ld_exec_seq.sv
// Directed scoreboard bench for the indexed load/store sequencer with a simple memory model.
module tb_xix_ld_exec_seq;
  import xix_pkg::*;

  localparam int AT = 5;

  logic        CLK = 1'b0;
  logic        notReset;
  logic        go;
  logic        is_Y;
  logic        is_store;
  logic [6:0]  reg_sel;
  logic [15:0] IX;
  logic [15:0] IY;
  logic [15:0] PC;
  logic [7:0]  reg_rdata;
  logic        notWAIT;
  logic [7:0]  mem_rdata;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic        pc_inc;
  logic        reg_we;
  logic [6:0]  reg_wsel;
  logic [7:0]  reg_wdata;
  logic        busy;
  logic        done;
  logic        err;

  logic [7:0] mem [0:65535];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        st;
    logic [15:0] ea;
    logic [7:0]  data;
    logic [6:0]  sel;
    int          lat;
  } exp_t;

  exp_t sb[$];

  always #5 CLK = ~CLK;

  assign mem_rdata = mem[mem_addr];

  xix_ld_exec_seq #(.ADDR_TSTATES(AT), .WAIT_ENABLE(1'b1)) dut (
    .CLK       (CLK),
    .notReset  (notReset),
    .go        (go),
    .is_Y      (is_Y),
    .is_store  (is_store),
    .reg_sel   (reg_sel),
    .IX        (IX),
    .IY        (IY),
    .PC        (PC),
    .reg_rdata (reg_rdata),
    .notWAIT   (notWAIT),
    .mem_rdata (mem_rdata),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .pc_inc    (pc_inc),
    .reg_we    (reg_we),
    .reg_wsel  (reg_wsel),
    .reg_wdata (reg_wdata),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic y, input logic st, input logic [6:0] sel,
                        input logic [15:0] base, input logic [15:0] pc, input logic [7:0] d,
                        input logic [7:0] data, input int d2w, input int m2w, input bit inj);
    exp_t        e;
    logic [15:0] ea;
    int          m1;
    int          done_c;
    int          bad_d, bad_m, bad_o, n_pc, n_we, n_wr;
    logic [6:0]  we_sel;
    logic [7:0]  we_data;
    ea = base + {{8{d[7]}}, d};
    mem[pc] = d;
    if (!st) mem[ea] = data;
    if (y) begin IY = base; IX = ~base; end
    else   begin IX = base; IY = ~base; end
    PC        = pc;
    reg_rdata = st ? data : 8'hEE;
    m1        = 3 + d2w + AT + 1;
    e.st   = st;
    e.ea   = ea;
    e.data = data;
    e.sel  = sel;
    e.lat  = 3 + d2w + AT + 3 + m2w + 1;
    sb.push_back(e);
    done_c = 0; bad_d = 0; bad_m = 0; bad_o = 0; n_pc = 0; n_we = 0; n_wr = 0;
    we_sel = 7'd0; we_data = 8'h00;
    @(negedge CLK);
    go = 1'b1; is_Y = y; is_store = st; reg_sel = sel;
    for (int c = 1; c <= 40 && done_c == 0; c++) begin
      @(negedge CLK);
      if (c == 1) go = 1'b0;
      notWAIT = !((c >= 2 && c < 2 + d2w) || (c >= m1 + 1 && c < m1 + 1 + m2w));
      if (inj && c == 5) begin go = 1'b1; is_Y = !y; is_store = !st; reg_sel = REG_C; end
      if (inj && c == 6) go = 1'b0;
      if (c <= 3 + d2w) begin
        if (mem_addr !== pc || mem_rd !== 1'b1 || mem_wr !== 1'b0) bad_d++;
      end else if (c >= m1 && c <= m1 + 2 + m2w) begin
        if (mem_addr !== ea || mem_rd !== !st || mem_wr !== (st && c > m1)) bad_m++;
        if (st && mem_wdata !== data) bad_m++;
        if (mem_wr === 1'b1) n_wr++;
      end else if (mem_rd !== 1'b0 || mem_wr !== 1'b0) begin
        bad_o++;
      end
      if (busy !== 1'b1 || err !== 1'b0) bad_o++;
      if (pc_inc === 1'b1) begin
        n_pc++;
        if (c != 3 + d2w) bad_d++;
      end
      if (reg_we === 1'b1) begin n_we++; we_sel = reg_wsel; we_data = reg_wdata; end
      if (done === 1'b1) done_c = c;
    end
    go = 1'b0; notWAIT = 1'b1;
    @(negedge CLK);
    check({tag, ":idle_after"}, {busy, done, reg_we, mem_rd, mem_wr}, 5'b0);
    if (sb.size() == 0) begin
      check({tag, ":sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, ":latency"}, done_c, e.lat);
      check({tag, ":disp_cycle"}, bad_d, 0);
      check({tag, ":mem_cycle"}, bad_m, 0);
      check({tag, ":other_cycles"}, bad_o, 0);
      check({tag, ":pc_inc_count"}, n_pc, 1);
      if (!e.st) begin
        check({tag, ":we_count"}, n_we, 1);
        check({tag, ":we_sel"}, we_sel, e.sel);
        check({tag, ":we_data"}, we_data, e.data);
      end else begin
        check({tag, ":we_count"}, n_we, 0);
        check({tag, ":wr_cycles"}, n_wr, 2 + m2w);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    notReset = 1'b0; go = 1'b0; is_Y = 1'b0; is_store = 1'b0; reg_sel = 7'd0;
    IX = 16'h0; IY = 16'h0; PC = 16'h0; reg_rdata = 8'h00; notWAIT = 1'b1;
    repeat (2) @(negedge CLK);
    check("rst:addr", mem_addr, 16'h0000);
    check("rst:strobes", {mem_rd, mem_wr, pc_inc, reg_we, done, err, busy}, 7'b0);
    check("rst:wsel", reg_wsel, 7'd0);
    notReset = 1'b1;
    @(negedge CLK);

    run_op("load_ix", 1'b0, 1'b0, REG_A, 16'h1000, 16'h2000, 8'h05, 8'h5A, 0, 0, 1'b0);
    run_op("store_iy_neg", 1'b1, 1'b1, REG_B, 16'h0100, 16'h3000, 8'hFE, 8'hC3, 0, 0, 1'b0);
    run_op("wrap_ffff", 1'b0, 1'b0, REG_H, 16'hFFFF, 16'h4000, 8'h01, 8'h77, 0, 0, 1'b0);
    run_op("waits_load", 1'b1, 1'b0, REG_E, 16'h2000, 16'h5000, 8'h10, 8'h3C, 2, 3, 1'b0);
    run_op("store_ff80", 1'b0, 1'b1, REG_D, 16'h0000, 16'h5800, 8'h80, 8'h69, 0, 1, 1'b0);

    @(negedge CLK);
    go = 1'b1; reg_sel = 7'b0000011;
    @(negedge CLK);
    go = 1'b0;
    check("badsel:err", err, 1'b1);
    check("badsel:busy", busy, 1'b0);
    @(negedge CLK);
    check("badsel:err_pulse", err, 1'b0);
    check("badsel:still_idle", busy, 1'b0);
    go = 1'b1; reg_sel = 7'd0;
    @(negedge CLK);
    go = 1'b0;
    check("zerosel:err", err, 1'b1);
    @(negedge CLK);

    run_op("busy_go", 1'b0, 1'b0, REG_L, 16'h1234, 16'h6000, 8'h7F, 8'hA5, 0, 0, 1'b1);

    mem[16'h7000] = 8'h02;
    IX = 16'h0500; IY = 16'hFAFF; PC = 16'h7000; reg_rdata = 8'h99;
    @(negedge CLK);
    go = 1'b1; is_Y = 1'b0; is_store = 1'b1; reg_sel = REG_B;
    for (int c = 1; c <= 10; c++) begin
      @(negedge CLK);
      if (c == 1) go = 1'b0;
    end
    check("rstmid:wr_before", mem_wr, 1'b1);
    check("rstmid:addr_before", mem_addr, 16'h0502);
    notReset = 1'b0;
    #1;
    check("rstmid:wr_drop", mem_wr, 1'b0);
    check("rstmid:addr_zero", mem_addr, 16'h0000);
    check("rstmid:outs_zero", {mem_rd, pc_inc, reg_we, done, err, busy}, 6'b0);
    check("rstmid:data_zero", {mem_wdata, reg_wdata, reg_wsel}, 23'd0);
    @(negedge CLK);
    notReset = 1'b1;
    @(negedge CLK);

    run_op("after_reset", 1'b1, 1'b0, REG_C, 16'h8000, 16'h9000, 8'hF0, 8'h42, 0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
